// File: rtl/ext_dispatch_unit_if.sv
// Dispatch bus between the main FSM, the dispatcher and its multi-cycle units.
// The slave side is the dispatcher; the master side drives requests and unit responses.
interface ext_dispatch_unit_if #(
  parameter int N_UNITS  = 2,
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 3
);
  localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic                    req_valid;
  logic [UW-1:0]           req_unit;
  logic [OP_WIDTH-1:0]     req_op;
  logic                    kill;
  logic                    req_ready;
  logic [N_UNITS-1:0]      unit_valid;
  logic [OP_WIDTH-1:0]     unit_op;
  logic [N_UNITS-1:0]      unit_ready;
  logic [N_UNITS*XLEN-1:0] unit_result;
  logic [XLEN-1:0]         result;
  logic                    done;
  logic                    error;
  logic                    busy;

  modport slave (
    input  req_valid, req_unit, req_op, kill, unit_ready, unit_result,
    output req_ready, unit_valid, unit_op, result, done, error, busy
  );

  modport master (
    output req_valid, req_unit, req_op, kill, unit_ready, unit_result,
    input  req_ready, unit_valid, unit_op, result, done, error, busy
  );
endinterface

// File: rtl/ext_dispatch_unit.sv
// Dispatches one operation at a time to a multi-cycle execution unit and
// waits for its completion, with kill, bad-index and timeout handling.
module ext_dispatch_unit #(
  parameter int N_UNITS  = 2,
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  ext_dispatch_unit_if.slave bus
);
  localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e              state_q;
  logic [UW-1:0]       sel_q;
  logic [CW-1:0]       cnt_q;
  logic [N_UNITS-1:0]  unit_valid_q;
  logic [OP_WIDTH-1:0] unit_op_q;
  logic [XLEN-1:0]     result_q;
  logic                done_q;
  logic                error_q;

  logic                req_ready;
  logic                accept;
  logic                idx_ok;
  logic                sel_ready;
  logic [XLEN-1:0]     sel_result;
  logic                timeout_hit;

  assign req_ready = (state_q == IDLE) && !reset && !bus.kill;
  assign accept    = bus.req_valid && req_ready;
  // Widened by one bit so the range check stays meaningful when N_UNITS is a power of two.
  assign idx_ok    = {1'b0, bus.req_unit} < (UW+1)'(N_UNITS);
  assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_q) + 1) == TIMEOUT);

  always_comb begin
    sel_ready  = 1'b0;
    sel_result = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel_q == UW'(i)) begin
        sel_ready  = bus.unit_ready[i];
        sel_result = bus.unit_result[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      unit_valid_q <= '0;
      unit_op_q    <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (idx_ok) begin
              sel_q     <= bus.req_unit;
              unit_op_q <= bus.req_op;
              cnt_q     <= '0;
              for (int i = 0; i < N_UNITS; i++)
                unit_valid_q[i] <= (bus.req_unit == UW'(i));
              state_q   <= WAIT;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          // kill has priority over a completion arriving the same cycle.
          if (bus.kill) begin
            unit_valid_q <= '0;
            state_q      <= IDLE;
          end else if (sel_ready) begin
            result_q     <= sel_result;
            unit_valid_q <= '0;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end else if (timeout_hit) begin
            unit_valid_q <= '0;
            error_q      <= 1'b1;
            state_q      <= IDLE;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.unit_valid = unit_valid_q;
  assign bus.unit_op    = unit_op_q;
  assign bus.result     = result_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ext_dispatch_unit.sv
// Directed bench for ext_dispatch_unit: two instances, one with a short
// timeout and two units, one with three units for the out-of-range index.
module tb_ext_dispatch_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ext_dispatch_unit_if #(.N_UNITS(2), .XLEN(32), .OP_WIDTH(3)) b1 ();
  ext_dispatch_unit_if #(.N_UNITS(3), .XLEN(32), .OP_WIDTH(3)) b2 ();

  ext_dispatch_unit #(.N_UNITS(2), .XLEN(32), .OP_WIDTH(3), .TIMEOUT(8)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  ext_dispatch_unit #(.N_UNITS(3), .XLEN(32), .OP_WIDTH(3), .TIMEOUT(0)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    b1.req_valid = 0; b1.req_unit = '0; b1.req_op = '0; b1.kill = 0;
    b1.unit_ready = '0; b1.unit_result = '0;
    b2.req_valid = 0; b2.req_unit = '0; b2.req_op = '0; b2.kill = 0;
    b2.unit_ready = '0; b2.unit_result = '0;
    tick(); tick();

    // reset state
    ck("rst_ready", b1.req_ready, 0);
    ck("rst_valid", b1.unit_valid, 0);
    ck("rst_result", b1.result, 0);
    ck("rst_done_err", {b1.done, b1.error, b1.busy}, 0);
    reset = 1'b0;
    #1 ck("rel_ready", b1.req_ready, 1);

    // mul: ready 3 cycles after valid
    b1.req_valid = 1; b1.req_unit = 0; b1.req_op = 3'b001;
    tick();
    b1.req_valid = 0;
    ck("mul_valid", b1.unit_valid, 2'b01);
    ck("mul_op", b1.unit_op, 3'b001);
    ck("mul_busy", {b1.busy, b1.req_ready}, 2'b10);
    tick();
    ck("mul_wait1", {b1.done, b1.unit_valid}, 3'b001);
    tick();
    ck("mul_wait2", {b1.done, b1.unit_valid}, 3'b001);
    b1.unit_ready = 2'b01; b1.unit_result[31:0] = 32'h12345678;
    tick();
    b1.unit_ready = 2'b00;
    ck("mul_done", {b1.done, b1.unit_valid}, 3'b100);
    ck("mul_result", b1.result, 32'h12345678);
    tick();
    ck("mul_after", {b1.done, b1.busy, b1.req_ready}, 3'b001);

    // div with unit 0 ready asserted throughout
    b1.unit_result[31:0] = 32'hAAAAAAAA;
    b1.unit_ready = 2'b01;
    b1.req_valid = 1; b1.req_unit = 1; b1.req_op = 3'b100;
    tick();
    b1.req_valid = 0;
    ck("div_valid", b1.unit_valid, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      ck("div_ign0", {b1.done, b1.busy, b1.unit_valid}, 4'b0110);
    end
    b1.unit_ready = 2'b11; b1.unit_result[63:32] = 32'hDEADBEEF;
    tick();
    b1.unit_ready = 2'b00;
    ck("div_done", {b1.done, b1.unit_valid}, 3'b100);
    ck("div_result", b1.result, 32'hDEADBEEF);
    tick();
    ck("div_once", {b1.done, b1.busy}, 2'b00);

    // timeout after exactly 8 WAIT cycles
    b1.req_valid = 1; b1.req_unit = 0; b1.req_op = 3'b010;
    tick();
    b1.req_valid = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      ck("to_wait", {b1.error, b1.unit_valid}, 3'b001);
    end
    tick();
    ck("to_fire", {b1.error, b1.unit_valid, b1.req_ready, b1.done}, 5'b10010);
    ck("to_result", b1.result, 32'hDEADBEEF);
    tick();
    ck("to_pulse", b1.error, 0);

    // kill together with unit_ready[1]
    b1.req_valid = 1; b1.req_unit = 1; b1.req_op = 3'b011;
    tick();
    b1.req_valid = 0;
    tick();
    b1.kill = 1; b1.unit_ready = 2'b10; b1.unit_result[63:32] = 32'h0BADF00D;
    tick();
    b1.kill = 0; b1.unit_ready = 2'b00;
    ck("kill_flags", {b1.done, b1.error, b1.busy, b1.unit_valid}, 5'b00000);
    ck("kill_result", b1.result, 32'hDEADBEEF);
    tick();
    ck("kill_nodone", b1.done, 0);

    // kill in IDLE blocks acceptance
    b1.kill = 1; b1.req_valid = 1; b1.req_unit = 0;
    #1 ck("kill_idle_rdy", b1.req_ready, 0);
    tick();
    b1.kill = 0; b1.req_valid = 0;
    ck("kill_idle_blk", {b1.busy, b1.unit_valid}, 3'b000);

    // reset in the middle of WAIT
    b1.req_valid = 1; b1.req_unit = 0; b1.req_op = 3'b101;
    tick();
    b1.req_valid = 0;
    ck("rw_valid", b1.unit_valid, 2'b01);
    reset = 1;
    tick();
    ck("rw_outs", {b1.unit_valid, b1.unit_op, b1.done, b1.error, b1.busy, b1.req_ready}, 0);
    ck("rw_result", b1.result, 0);
    reset = 0;
    b1.req_valid = 1; b1.req_unit = 1; b1.req_op = 3'b010;
    tick();
    b1.req_valid = 0;
    ck("rw_accept", {b1.unit_valid, b1.unit_op}, 5'b10010);
    b1.unit_ready = 2'b10; b1.unit_result[63:32] = 32'h00C0FFEE;
    tick();
    b1.unit_ready = 2'b00;
    ck("rw_done", {b1.done, b1.result}, {1'b1, 32'h00C0FFEE});

    // three-unit instance: valid op on unit 2, then out-of-range index 3
    b2.req_valid = 1; b2.req_unit = 2; b2.req_op = 3'b110;
    tick();
    b2.req_valid = 0;
    ck("u3_valid", b2.unit_valid, 3'b100);
    b2.unit_ready = 3'b100; b2.unit_result[95:64] = 32'h000055AA;
    tick();
    b2.unit_ready = 3'b000;
    ck("u3_result", {b2.done, b2.result}, {1'b1, 32'h000055AA});
    tick();
    b2.req_valid = 1; b2.req_unit = 3; b2.req_op = 3'b111;
    tick();
    b2.req_valid = 0;
    ck("bad_err", {b2.error, b2.unit_valid, b2.busy, b2.done}, 6'b100000);
    ck("bad_result", b2.result, 32'h000055AA);
    tick();
    ck("bad_pulse", {b2.error, b2.req_ready}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
